// File: rtl/trdb_packet_deframer.sv
// Rebuilds trace packets from a header-framed byte stream and presents one payload at a time.
// packet_valid_o rises the cycle after the last payload byte; byte_ready_o is low while a packet is held.
module trdb_packet_deframer #(
  parameter int MAX_PAYLOAD_BYTES = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           byte_valid_i,
  input  logic [7:0]                     byte_i,
  output logic                           byte_ready_o,
  output logic                           packet_valid_o,
  input  logic                           packet_ready_i,
  output logic [8*MAX_PAYLOAD_BYTES-1:0] payload_o,
  output logic [4:0]                     payload_len_o,
  output logic [1:0]                     flow_o,
  output logic [1:0]                     packet_format_o,
  output logic [1:0]                     packet_f_sync_subformat_o,
  output logic                           err_o,
  output logic [7:0]                     drop_cnt_o
);

  localparam logic [4:0] MAX_LEN = 5'(MAX_PAYLOAD_BYTES);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD, DISCARD} state_t;

  state_t     state;
  logic [4:0] idx;
  logic [4:0] remaining;

  logic       xfer;
  logic [4:0] hdr_len;
  logic [1:0] hdr_flow;
  logic       hdr_ext;

  assign xfer     = byte_valid_i & byte_ready_o;
  assign hdr_len  = byte_i[4:0];
  assign hdr_flow = byte_i[6:5];
  assign hdr_ext  = byte_i[7];

  // Format fields are a view of the held payload, so they track it exactly.
  assign packet_format_o           = payload_o[1:0];
  assign packet_f_sync_subformat_o = (payload_o[1:0] == 2'b11) ? payload_o[3:2] : 2'b00;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      idx            <= '0;
      remaining      <= '0;
      byte_ready_o   <= 1'b1;
      packet_valid_o <= 1'b0;
      payload_o      <= '0;
      payload_len_o  <= '0;
      flow_o         <= '0;
      err_o          <= 1'b0;
      drop_cnt_o     <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (hdr_ext || (hdr_len > MAX_LEN)) begin
              err_o     <= 1'b1;
              remaining <= hdr_len;
              if (drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
              // An extended header with no body has nothing left to skip.
              if (hdr_len != 5'd0) state <= DISCARD;
            end else if (hdr_len != 5'd0) begin
              payload_o     <= '0;
              payload_len_o <= hdr_len;
              flow_o        <= hdr_flow;
              idx           <= '0;
              state         <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (xfer) begin
            payload_o[{idx, 3'b000} +: 8] <= byte_i;
            idx <= idx + 5'd1;
            if ((idx + 5'd1) == payload_len_o) begin
              state          <= HOLD;
              packet_valid_o <= 1'b1;
              byte_ready_o   <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (packet_ready_i) begin
            state          <= IDLE;
            packet_valid_o <= 1'b0;
            byte_ready_o   <= 1'b1;
          end
        end
        DISCARD: begin
          if (xfer) begin
            remaining <= remaining - 5'd1;
            if (remaining == 5'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trdb_packet_deframer.sv
// Directed bench for trdb_packet_deframer at the default 16-byte payload limit.
module tb_trdb_packet_deframer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         byte_valid;
  logic [7:0]   byte_d;
  logic         byte_ready;
  logic         packet_valid;
  logic         packet_ready;
  logic [127:0] payload;
  logic [4:0]   payload_len;
  logic [1:0]   flow;
  logic [1:0]   fmt;
  logic [1:0]   sub;
  logic         err;
  logic [7:0]   drop_cnt;

  int passed = 0;
  int total  = 0;
  logic pv_seen;

  always #5 clk = ~clk;

  trdb_packet_deframer #(.MAX_PAYLOAD_BYTES(16)) dut (
    .clk_i                     (clk),
    .rst_ni                    (rst_n),
    .byte_valid_i              (byte_valid),
    .byte_i                    (byte_d),
    .byte_ready_o              (byte_ready),
    .packet_valid_o            (packet_valid),
    .packet_ready_i            (packet_ready),
    .payload_o                 (payload),
    .payload_len_o             (payload_len),
    .flow_o                    (flow),
    .packet_format_o           (fmt),
    .packet_f_sync_subformat_o (sub),
    .err_o                     (err),
    .drop_cnt_o                (drop_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called on a falling edge; returns on the falling edge after the byte transfers.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_d     = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 128'(byte_ready), 128'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic ack();
    packet_ready = 1'b1;
    @(negedge clk);
    packet_ready = 1'b0;
    chk("ack_valid_low", 128'(packet_valid), 128'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    byte_valid   = 1'b0;
    byte_d       = 8'h00;
    packet_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid",   128'(packet_valid), 128'd0);
    chk("rst_ready",   128'(byte_ready),   128'd1);
    chk("rst_payload", payload,            128'd0);
    chk("rst_drop",    128'(drop_cnt),     128'd0);
    chk("rst_err",     128'(err),          128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-byte sync packet
    send(8'h02);
    send(8'hA7);
    chk("p1_not_yet", 128'(packet_valid), 128'd0);
    send(8'h3C);
    chk("p1_valid",   128'(packet_valid), 128'd1);
    chk("p1_payload", payload,            128'h3CA7);
    chk("p1_len",     128'(payload_len),  128'd2);
    chk("p1_fmt",     128'(fmt),          128'd3);
    chk("p1_sub",     128'(sub),          128'd1);
    chk("p1_ready",   128'(byte_ready),   128'd0);
    ack();
    chk("p1_ready_back", 128'(byte_ready), 128'd1);

    // Flow 3, held under backpressure
    send(8'h61);
    send(8'h02);
    for (int i = 0; i < 5; i++) begin
      chk("p2_hold_valid",   128'(packet_valid), 128'd1);
      chk("p2_hold_ready",   128'(byte_ready),   128'd0);
      chk("p2_hold_payload", payload,            128'h02);
      chk("p2_hold_flow",    128'(flow),         128'd3);
      chk("p2_hold_fmt",     128'(fmt),          128'd2);
      chk("p2_hold_sub",     128'(sub),          128'd0);
      @(negedge clk);
    end
    // Byte offered together with the handshake must not be consumed
    byte_valid   = 1'b1;
    byte_d       = 8'h01;
    packet_ready = 1'b1;
    @(negedge clk);
    packet_ready = 1'b0;
    chk("p2_released", 128'(packet_valid), 128'd0);
    send(8'h01);
    send(8'h55);
    chk("p3_valid",   128'(packet_valid), 128'd1);
    chk("p3_payload", payload,            128'h55);
    chk("p3_len",     128'(payload_len),  128'd1);
    chk("p3_flow",    128'(flow),         128'd0);
    chk("p3_fmt",     128'(fmt),          128'd1);
    ack();

    // Filler then single zero byte
    send(8'h00);
    chk("fill_err",   128'(err),          128'd0);
    chk("fill_valid", 128'(packet_valid), 128'd0);
    send(8'h01);
    send(8'h00);
    chk("p4_valid",   128'(packet_valid), 128'd1);
    chk("p4_len",     128'(payload_len),  128'd1);
    chk("p4_payload", payload,            128'd0);
    ack();

    // Oversized header: 17 bytes discarded
    send(8'h11);
    chk("ovr_err",  128'(err),      128'd1);
    chk("ovr_drop", 128'(drop_cnt), 128'd1);
    pv_seen = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send(8'hC3);
      if (i == 0) chk("ovr_err_once", 128'(err), 128'd0);
      pv_seen = pv_seen | packet_valid;
    end
    chk("ovr_no_valid", 128'(pv_seen), 128'd0);
    send(8'h03);
    send(8'h0B);
    send(8'h22);
    send(8'h44);
    chk("p5_valid",   128'(packet_valid), 128'd1);
    chk("p5_payload", payload,            128'h44220B);
    chk("p5_len",     128'(payload_len),  128'd3);
    chk("p5_fmt",     128'(fmt),          128'd3);
    chk("p5_sub",     128'(sub),          128'd2);
    chk("p5_drop",    128'(drop_cnt),     128'd1);
    ack();

    // Extend bit set: one byte skipped
    send(8'h81);
    chk("ext_err",  128'(err),      128'd1);
    chk("ext_drop", 128'(drop_cnt), 128'd2);
    send(8'h5A);
    chk("ext_no_valid", 128'(packet_valid), 128'd0);
    chk("ext_err_low",  128'(err),          128'd0);
    send(8'h01);
    send(8'h06);
    chk("p6_payload", payload,        128'h06);
    chk("p6_fmt",     128'(fmt),      128'd2);
    ack();

    // Reset in the middle of an 8-byte packet
    send(8'h08);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",   128'(packet_valid), 128'd0);
    chk("mid_rst_payload", payload,            128'd0);
    chk("mid_rst_len",     128'(payload_len),  128'd0);
    chk("mid_rst_drop",    128'(drop_cnt),     128'd0);
    chk("mid_rst_ready",   128'(byte_ready),   128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h21);
    send(8'h0D);
    chk("p7_valid",   128'(packet_valid), 128'd1);
    chk("p7_payload", payload,            128'h0D);
    chk("p7_len",     128'(payload_len),  128'd1);
    chk("p7_flow",    128'(flow),         128'd1);
    chk("p7_fmt",     128'(fmt),          128'd1);
    ack();

    // Drop counter saturation
    for (int i = 0; i < 256; i++) begin
      send(8'h81);
      send(8'h00);
    end
    chk("drop_sat", 128'(drop_cnt), 128'd255);
    send(8'h81);
    chk("drop_sat_err", 128'(err),      128'd1);
    chk("drop_sat_hold", 128'(drop_cnt), 128'd255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/trdb_packet_deframer.md
# trdb_packet_deframer

Receive-side counterpart of the trace encoder's packet path. Accepts the encapsulated trace byte stream one byte per cycle, strips the header, and reassembles one payload per packet. Presents the payload with its decoded packet format and sync subformat through a valid/ready handshake. Sits in the trace debugger's sink/checker path, so that packets produced by the priority and packet-emitter logic can be reconstructed and compared field by field.

## Interface
Parameters:
- MAX_PAYLOAD_BYTES, 16, largest payload accepted; legal range 1..31.

Ports:
- clk_i  in  1  clock; everything samples on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- byte_valid_i  in  1  byte_i holds a stream byte.
- byte_i  in  8  stream byte.
- byte_ready_o  out  1  deframer can accept a byte this cycle.
- packet_valid_o  out  1  a reassembled packet is held on the outputs.
- packet_ready_i  in  1  downstream consumes the packet.
- payload_o  out  8*MAX_PAYLOAD_BYTES  payload, little-endian: byte k at bits [8k+7:8k].
- payload_len_o  out  5  number of payload bytes, 1..MAX_PAYLOAD_BYTES.
- flow_o  out  2  header flow field.
- packet_format_o  out  2  payload bits [1:0].
- packet_f_sync_subformat_o  out  2  payload bits [3:2] when the format is 2'b11; otherwise 0.
- err_o  out  1  one-cycle pulse when a bad header is accepted.
- drop_cnt_o  out  8  saturating count of discarded packets.

## Operation
- Header byte layout: [4:0] len, [6:5] flow, [7] extend.
- A byte transfers when byte_valid_i and byte_ready_o are both high.
- byte_ready_o is 1 in IDLE, COLLECT and DISCARD, and 0 in HOLD.
- FSM states: IDLE, COLLECT, HOLD, DISCARD.
- IDLE, header transferred:
  - len==0: idle filler. Stay in IDLE; no output, no error.
  - extend==1 or len>MAX_PAYLOAD_BYTES: pulse err_o, increment drop_cnt_o, load the remaining count with len, go to DISCARD. If len==0 with extend==1, pulse the error and stay in IDLE.
  - Otherwise: clear the payload buffer to all zeros, latch len and flow, clear the byte index, go to COLLECT.
- COLLECT, byte transferred:
  - Write the byte at the current index and increment the index.
  - When the index reaches len, go to HOLD.
- HOLD:
  - packet_valid_o=1.
  - All packet outputs are stable until the handshake.
  - When packet_ready_i=1, go to IDLE.
- DISCARD:
  - Decrement the remaining count on each transfer.
  - Go to IDLE on the transfer that brings it to 0.
- Unreceived payload bytes read as zero.
- packet_format_o and packet_f_sync_subformat_o are decoded from the held payload.
- drop_cnt_o saturates at 255.
- Reset (asynchronous, any state, including mid-packet):
  - FSM returns to IDLE.
  - A partial packet is lost and not counted.
  - All outputs go to 0 except byte_ready_o, which is 1 once in IDLE.

## Timing
- Outputs are registered. packet_valid_o rises the cycle after the last payload byte transfers.
- The HOLD→IDLE handshake costs one cycle. The next header is accepted no earlier than the cycle after packet_valid_o falls.
- Minimum packet period: 1 header + len payload + 1 handshake cycle.
- byte_valid_i low simply stalls the FSM; there is no timeout.
- err_o is high for exactly the cycle after the bad header transfers.
- Simultaneous packet_ready_i and byte_valid_i in HOLD: the handshake completes and the byte is not consumed (byte_ready_o=0).

## Test plan
- Header 0x02, bytes 0xA7, 0x3C:
  - packet_valid_o one cycle after 0x3C.
  - payload_o[15:0]=0x3CA7, payload_len_o=2.
  - packet_format_o=2'b11, packet_f_sync_subformat_o=2'b01.
  - All upper payload bits 0.
- Header 0x61 then byte 0x02:
  - flow_o=2'b11, packet_format_o=2'b10, packet_f_sync_subformat_o=0.
  - Hold packet_ready_i=0 for 5 cycles: outputs stable and byte_ready_o=0 throughout.
- Header 0x00, then header 0x01 and byte 0x00:
  - No output or error for the filler byte.
  - One packet with payload_len_o=1.
- Header len=MAX_PAYLOAD_BYTES+1 (0x11 at default), followed by 17 bytes and then a valid packet:
  - err_o pulses once, drop_cnt_o=1.
  - No packet_valid_o for the oversized packet.
  - The following packet decodes correctly.
- Header 0x81 (extend set), then one byte:
  - err_o pulses, drop_cnt_o increments, the byte is discarded.
- rst_ni low after 3 of 8 payload bytes:
  - Immediate IDLE with all outputs 0.
  - After release, a new 1-byte packet decodes with the old bytes absent.
- 256 bad headers:
  - drop_cnt_o stays at 255.
